// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
//
// Forwarding and hazard controller for the execute stage of a 5-stage
// RISC-V pipeline. A shadow pipeline (EX, MEM, WB) follows the destination
// register of every in-flight instruction. From it the block drives the
// selects of the two EX operand muxes and the stall/flush controls that
// gate PC, IF/ID and ID/EX.
//
// Build option: define FWD_EN to enable operand forwarding with a single
// load-use bubble. Without FWD_EN the selects are tied to 0 and the block
// stalls until every used source has left EX and MEM.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid_i               ID holds a real instruction
//   id_rs1_i, id_rs2_i       ID source register indices
//   id_use_rs1_i/_rs2_i      ID instruction reads rs1 / rs2
//   id_rd_i                  ID destination register index
//   id_reg_write_i           ID instruction writes rd
//   id_mem_read_i            ID instruction is a load
//   ex_branch_taken_i        branch/jump resolved taken in EX
//   fwd_a_sel_o/fwd_b_sel_o  0 regfile, 1 EX/MEM result, 2 MEM/WB result
//   pc_write_en_o            PC may update
//   ifid_write_en_o          IF/ID may update
//   ifid_flush_o             clear IF/ID
//   idex_flush_o             load a bubble into ID/EX
//   stall_cycles_o           saturating count of cycles with PC held
module hazard_fwd_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid_i,
    input  logic [REG_ADDR_W-1:0]  id_rs1_i,
    input  logic [REG_ADDR_W-1:0]  id_rs2_i,
    input  logic                   id_use_rs1_i,
    input  logic                   id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0]  id_rd_i,
    input  logic                   id_reg_write_i,
    input  logic                   id_mem_read_i,
    input  logic                   ex_branch_taken_i,
    output logic [1:0]             fwd_a_sel_o,
    output logic [1:0]             fwd_b_sel_o,
    output logic                   pc_write_en_o,
    output logic                   ifid_write_en_o,
    output logic                   ifid_flush_o,
    output logic                   idex_flush_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o
);

    // Shadow pipeline: _p0 = EX, _p1 = MEM, _p2 = WB
    logic                  vld_p0, vld_p1, vld_p2;
    logic [REG_ADDR_W-1:0] rd_p0, rd_p1, rd_p2;
    logic                  rw_p0, rw_p1, rw_p2;
    logic                  mr_p0, mr_p1, mr_p2;

    logic ex_wr, mem_wr, stall;

    function automatic logic src_hit(input logic use_bit,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rd);
        return use_bit && (rs == rd);
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == '1) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // x0 is hard-wired zero, so a write to it never creates a dependency
    assign ex_wr  = vld_p0 && rw_p0 && (rd_p0 != '0);
    assign mem_wr = vld_p1 && rw_p1 && (rd_p1 != '0);

`ifdef FWD_EN
    typedef enum logic {IDLE, LU_STALL} state_t;
    state_t state;
    logic   lu_hazard;

    // Only a load still in EX cannot be forwarded in time
    assign lu_hazard = id_valid_i && ex_wr && mr_p0 &&
                       (src_hit(id_use_rs1_i, id_rs1_i, rd_p0) ||
                        src_hit(id_use_rs2_i, id_rs2_i, rd_p0));
    assign stall = (state == IDLE) && lu_hazard && !ex_branch_taken_i;

    // After one bubble the load sits in MEM and is forwarded from MEM/WB
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (ex_branch_taken_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (lu_hazard) state <= LU_STALL;
                LU_STALL: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // EX/MEM result has priority: it is the younger producer
    function automatic logic [1:0] fwd_sel(input logic use_bit,
                                           input logic [REG_ADDR_W-1:0] rs);
        if (use_bit && ex_wr && !mr_p0 && (rs == rd_p0))
            return 2'd1;
        else if (use_bit && mem_wr && (rs == rd_p1))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    // Selects are registered so they line up with the instruction in EX
    always_ff @(posedge clk) begin
        if (rst || idex_flush_o || !id_valid_i) begin
            fwd_a_sel_o <= 2'd0;
            fwd_b_sel_o <= 2'd0;
        end else begin
            fwd_a_sel_o <= fwd_sel(id_use_rs1_i, id_rs1_i);
            fwd_b_sel_o <= fwd_sel(id_use_rs2_i, id_rs2_i);
        end
    end
`else
    // No bypass paths: hold the reader until its producers are past MEM
    assign stall = id_valid_i && !ex_branch_taken_i &&
                   ((ex_wr  && (src_hit(id_use_rs1_i, id_rs1_i, rd_p0) ||
                                src_hit(id_use_rs2_i, id_rs2_i, rd_p0))) ||
                    (mem_wr && (src_hit(id_use_rs1_i, id_rs1_i, rd_p1) ||
                                src_hit(id_use_rs2_i, id_rs2_i, rd_p1))));

    assign fwd_a_sel_o = 2'd0;
    assign fwd_b_sel_o = 2'd0;
`endif

    // A taken branch overrides any stall
    assign pc_write_en_o   = !stall;
    assign ifid_write_en_o = !stall;
    assign ifid_flush_o    = ex_branch_taken_i;
    assign idex_flush_o    = stall || ex_branch_taken_i;

    // ID -> EX -> MEM -> WB
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= id_valid_i && !idex_flush_o;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        rd_p0 <= id_rd_i;
        rw_p0 <= id_reg_write_i;
        mr_p0 <= id_mem_read_i;
        rd_p1 <= rd_p0;
        rw_p1 <= rw_p0;
        mr_p1 <= mr_p0;
        rd_p2 <= rd_p1;
        rw_p2 <= rw_p1;
        mr_p2 <= mr_p1;
    end

    // The register file is write-through, so the WB entry never feeds a
    // decision; it is kept so the shadow pipeline mirrors the real one.
    logic unused_shadow;
    assign unused_shadow = ^{vld_p2, rd_p2, rw_p2, mr_p2, mr_p1, mr_p0};

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles_o <= '0;
        else if (!pc_write_en_o)
            stall_cycles_o <= sat_inc(stall_cycles_o);
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam logic [7:0] N = 8'hC0;  // pc_we=1 ifid_we=1, no flush, selects 0
    localparam logic [7:0] S = 8'h10;  // stall: pc/ifid held, ID/EX bubble
    localparam logic [7:0] B = 8'hF0;  // taken branch: both flushes, no hold

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic          id_reg_write = 1'b0, id_mem_read = 1'b0, br_taken = 1'b0;
    logic [1:0]    fa, fb;
    logic          pc_we, ifid_we, ifid_fl, idex_fl;
    logic [CW-1:0] cnt;

    logic [11:0]   exp_q[$];
    logic [11:0]   act_q[$];
    logic [CW-1:0] exp_cnt = '0;
    int            checks = 0;
    int            passed = 0;

    hazard_fwd_ctrl #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_rd_i(id_rd), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
        .ex_branch_taken_i(br_taken),
        .fwd_a_sel_o(fa), .fwd_b_sel_o(fb),
        .pc_write_en_o(pc_we), .ifid_write_en_o(ifid_we),
        .ifid_flush_o(ifid_fl), .idex_flush_o(idex_fl),
        .stall_cycles_o(cnt)
    );

    always #5 clk = ~clk;

    // One ID cycle: drive, record the expected outputs, sample mid-cycle
    task automatic cyc(input int v, input int a, input int b, input int ua, input int ub,
                       input int d, input int w, input int m, input int br,
                       input logic [7:0] e);
        @(negedge clk);
        id_valid     = (v != 0);
        id_rs1       = AW'(a);
        id_rs2       = AW'(b);
        id_use_rs1   = (ua != 0);
        id_use_rs2   = (ub != 0);
        id_rd        = AW'(d);
        id_reg_write = (w != 0);
        id_mem_read  = (m != 0);
        br_taken     = (br != 0);
        exp_q.push_back({e, exp_cnt});
        #2;
        act_q.push_back({pc_we, ifid_we, ifid_fl, idex_fl, fa, fb, cnt});
        if (!e[7] && exp_cnt != '1) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic nop(input logic [7:0] e);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endtask

    task automatic test_reset;
        logic [11:0] e, a;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        nop(N);
        nop(N);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) $display("FAIL reset: ctrl=%h cnt=%0d, expected ctrl=%h cnt=%0d", a[11:4], a[3:0], e[11:4], e[3:0]);
            else passed++;
        end
    endtask

    // add x5,x1,x2 ; sub x6,x5,x1
    task automatic test_ex_dep;
        logic [11:0] e, a;
        cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, N);
`ifdef FWD_EN
        cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, N);
        nop(8'hC4);
        nop(N);
`else
        cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, S);
        cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, S);
        cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, N);
        nop(N);
        nop(N);
`endif
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) $display("FAIL ex_dep: ctrl=%h cnt=%0d, expected ctrl=%h cnt=%0d", a[11:4], a[3:0], e[11:4], e[3:0]);
            else passed++;
        end
    endtask

    // add x5,x1,x2 ; nop ; or x7,x5,x5
    task automatic test_mem_dep;
        logic [11:0] e, a;
        cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, N);
        nop(N);
`ifdef FWD_EN
        cyc(1, 5, 5, 1, 1, 7, 1, 0, 0, N);
        nop(8'hCA);
        nop(N);
`else
        cyc(1, 5, 5, 1, 1, 7, 1, 0, 0, S);
        cyc(1, 5, 5, 1, 1, 7, 1, 0, 0, N);
        nop(N);
        nop(N);
`endif
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) $display("FAIL mem_dep: ctrl=%h cnt=%0d, expected ctrl=%h cnt=%0d", a[11:4], a[3:0], e[11:4], e[3:0]);
            else passed++;
        end
    endtask

    // lw x3,0(x1) ; add x4,x3,x2
    task automatic test_load_use;
        logic [11:0] e, a;
        cyc(1, 1, 0, 1, 0, 3, 1, 1, 0, N);
        cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, S);
`ifdef FWD_EN
        cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, N);
        nop(8'hC8);
        nop(N);
`else
        cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, S);
        cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, N);
        nop(N);
        nop(N);
`endif
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) $display("FAIL load_use: ctrl=%h cnt=%0d, expected ctrl=%h cnt=%0d", a[11:4], a[3:0], e[11:4], e[3:0]);
            else passed++;
        end
    endtask

    // addi x0,x1 ; add x8,x0,x0 ; lw x0 ; add x8,x0,x0
    task automatic test_x0;
        logic [11:0] e, a;
        cyc(1, 1, 0, 1, 0, 0, 1, 0, 0, N);
        cyc(1, 0, 0, 1, 1, 8, 1, 0, 0, N);
        nop(N);
        nop(N);
        cyc(1, 1, 0, 1, 0, 0, 1, 1, 0, N);
        cyc(1, 0, 0, 1, 1, 8, 1, 0, 0, N);
        nop(N);
        nop(N);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) $display("FAIL x0: ctrl=%h cnt=%0d, expected ctrl=%h cnt=%0d", a[11:4], a[3:0], e[11:4], e[3:0]);
            else passed++;
        end
    endtask

    // Branch in the same cycle as a load-use hazard, then during a stall
    task automatic test_branch;
        logic [11:0] e, a;
        cyc(1, 1, 0, 1, 0, 3, 1, 1, 0, N);
        cyc(1, 3, 2, 1, 1, 4, 1, 0, 1, B);
        nop(N);
        nop(N);
        cyc(1, 1, 0, 1, 0, 3, 1, 1, 0, N);
        cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, S);
        cyc(1, 3, 2, 1, 1, 4, 1, 0, 1, B);
        nop(N);
        nop(N);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) $display("FAIL branch: ctrl=%h cnt=%0d, expected ctrl=%h cnt=%0d", a[11:4], a[3:0], e[11:4], e[3:0]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_stall;
        logic [11:0] e, a;
        cyc(1, 1, 0, 1, 0, 3, 1, 1, 0, N);
        cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, S);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        // same dependent add still in ID, but the load was discarded
        cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, N);
        nop(N);
        nop(N);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) $display("FAIL reset_mid_stall: ctrl=%h cnt=%0d, expected ctrl=%h cnt=%0d", a[11:4], a[3:0], e[11:4], e[3:0]);
            else passed++;
        end
    endtask

    // Repeated load-use pairs drive the 4-bit counter into saturation
    task automatic test_saturate;
        logic [11:0] e, a;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 1, 0, 3, 1, 1, 0, N);
            cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, S);
`ifdef FWD_EN
            cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, N);
            nop(8'hC8);
`else
            cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, S);
            cyc(1, 3, 2, 1, 1, 4, 1, 0, 0, N);
            nop(N);
`endif
        end
        nop(N);
        nop(N);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) $display("FAIL saturate: ctrl=%h cnt=%0d, expected ctrl=%h cnt=%0d", a[11:4], a[3:0], e[11:4], e[3:0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_ex_dep();
        test_mem_dep();
        test_load_use();
        test_x0();
        test_branch();
        test_reset_mid_stall();
        test_saturate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
